pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic elastic pipeline register; successor to the fixed-field stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque data payload and a control payload, with valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and flush with bubble insertion.
- Control fields are forced to zero whenever the stage holds no valid beat, so a bubble never writes the register file or memory.

Parameters:
- DATA_W, 128, payload width (RD, immediate, ALU result, PC+4, memory data, ...).
- CTRL_W, 8, control payload width (regwrite_en, wb_src, memwrite, ...); zeroed on bubble.
- CNT_W, 16, width of performance counters; used only with PIPE_PERF_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill all beats held in and entering the stage this cycle.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat; registered.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  held data payload.
- out_ctrl  out  CTRL_W  held control payload; zero when out_valid=0.
- stall_cnt  out  CNT_W  PIPE_PERF_EN only.
- bubble_cnt  out  CNT_W  PIPE_PERF_EN only.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Storage: main entry (m_valid, m_data, m_ctrl) drives the outputs; skid entry (s_valid, s_data, s_ctrl) absorbs one beat under backpressure.
- Reset: m_valid=0, s_valid=0, all data/ctrl registers 0, in_ready=1, out_valid=0, out_data=0, out_ctrl=0, counters 0. Reset overrides flush and all handshakes.
- Handshake: upstream transfer occurs when in_valid && in_ready; downstream transfer occurs when out_valid && out_ready.
- Outputs: out_valid=m_valid; out_data=m_data; out_ctrl=m_ctrl gated by m_valid (all-zero when m_valid=0).
- in_ready = !s_valid, registered (a function of state only, not of out_ready).
- Latency: 1 cycle from accepted input to out_valid when the stage is empty.
- Throughput: 1 beat/cycle while out_ready=1.
- Next-state rules, applied when flush=0:
  - Main empty or draining this cycle, skid empty: an accepted input loads main.
  - Main empty or draining, skid full: skid moves to main and s_valid clears. in_ready=0 this cycle, so no input is accepted.
  - Main full and stalled (out_ready=0), input accepted: beat goes to skid and in_ready drops next cycle.
  - Main full, stalled, skid full: hold all state.
- Ordering: beats leave strictly in arrival order; no beat is ever dropped or duplicated without flush.
- Flush (flush=1, rst=0):
  - Next cycle m_valid=0, s_valid=0, m_ctrl=0, s_ctrl=0; data registers hold their values.
  - A beat presented in the flush cycle is discarded, even if in_ready=1.
  - The downstream transfer in the flush cycle still completes if out_valid && out_ready.
  - in_ready=1 the cycle after a flush.
- Boundaries:
  - out_ready toggling every cycle must not lose beats.
  - Simultaneous skid-to-main move and input with in_ready=0: the input is not accepted and upstream must hold it.
  - Reset mid-stall empties both entries.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at 2^CNT_W-1, are cleared by rst, and are not affected by flush.
- Undefined: stall_cnt, bubble_cnt and their logic are absent from the module.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 with in_data=0x1..0x5, in_ctrl=0x03, out_ready=1 -> out_valid from cycle 1 after first accept; data 0x1..0x5 back-to-back; in_ready stays 1.
- Backpressure skid: main holds 0xA, out_ready=0, send 0xB -> 0xB accepted, in_ready=0 next cycle; out_ready=1 -> 0xA then 0xB out on consecutive cycles; in_ready=1 after 0xB moves to main.
- Flush: main=0xC (ctrl=0x01), skid=0xD, flush=1 with in_valid=1 data 0xE -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1; 0xC/0xD/0xE never appear at output.
- Random out_ready (50%) and in_valid (70%) over 1000 beats, counting data -> output sequence equals input sequence; out_ctrl==0 whenever out_valid=0.
- Reset mid-stall: both entries full, assert rst -> next cycle out_valid=0, in_ready=1, out_data=0.
- PIPE_PERF_EN with CNT_W=4: hold out_ready=0 for 20 cycles with main valid -> stall_cnt saturates at 15; idle 3 cycles after drain -> bubble_cnt advances by 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ============================================================================
//  Module   : pipe_stage_reg
//  Brief    : Elastic pipeline register with 2-entry skid buffer, flush and
//             bubble control-zeroing. Define PIPE_PERF_EN to add the
//             saturating stall/bubble performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;
    logic [CTRL_W-1:0] r_s_ctrl;

    logic w_up_xfer;
    logic w_main_free;

    // in_ready depends only on the skid flop, never on out_ready
    assign in_ready    = !r_s_valid;
    assign w_up_xfer   = in_valid && in_ready;
    assign w_main_free = !r_m_valid || out_ready;

    assign out_valid = r_m_valid;
    assign out_data  = r_m_data;
    assign out_ctrl  = r_m_valid ? r_m_ctrl : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ctrl  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_ctrl  <= '0;
        end else if (flush) begin
            // data registers deliberately keep their values
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
        end else if (w_main_free) begin
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_s_data;
                r_m_ctrl  <= r_s_ctrl;
                r_s_valid <= 1'b0;
                r_s_ctrl  <= '0;
            end else if (w_up_xfer) begin
                r_m_valid <= 1'b1;
                r_m_data  <= in_data;
                r_m_ctrl  <= in_ctrl;
            end else begin
                r_m_valid <= 1'b0;
                r_m_ctrl  <= '0;
            end
        end else if (w_up_xfer) begin
            // main is stalled: park the accepted beat in the skid entry
            r_s_valid <= 1'b1;
            r_s_data  <= in_data;
            r_s_ctrl  <= in_ctrl;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_m_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!r_m_valid && (r_bubble_cnt != {CNT_W{1'b1}}))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    if (CNT_W > 0) begin : g_no_perf
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Brief    : Self-checking bench for pipe_stage_reg (directed vectors).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int c_DATA_W = 128;
    localparam int c_CTRL_W = 8;
    localparam int c_CNT_W  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [c_DATA_W-1:0] in_data = '0;
    logic [c_CTRL_W-1:0] in_ctrl = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [c_DATA_W-1:0] out_data;
    logic [c_CTRL_W-1:0] out_ctrl;
`ifdef PIPE_PERF_EN
    logic [c_CNT_W-1:0]  stall_cnt;
    logic [c_CNT_W-1:0]  bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(
        .DATA_W (c_DATA_W),
        .CTRL_W (c_CTRL_W),
        .CNT_W  (c_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    logic [127:0] q_data[$];
    logic [7:0]   q_ctrl[$];

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic acc;

        // ---------------- reset ----------------
        do_reset();
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_ctrl", out_ctrl, 0);

        // ---------------- stream 1..5 ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h03;
        for (int i = 1; i <= 5; i++) begin
            in_data = 128'(i);
            check_val("str_in_ready", in_ready, 1);
            step();
            check_val("str_out_valid", out_valid, 1);
            check_val("str_out_data", out_data, 128'(i));
            check_val("str_out_ctrl", out_ctrl, 8'h03);
        end
        in_valid = 1'b0;
        step();
        check_val("str_drained_valid", out_valid, 0);
        check_val("str_drained_ctrl", out_ctrl, 0);

        // ---------------- backpressure / skid ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'hA;
        in_ctrl   = 8'h01;
        step();
        in_data = 128'hB;
        in_ctrl = 8'h02;
        check_val("bp_in_ready_b", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_val("bp_in_ready_low", in_ready, 0);
        check_val("bp_hold_a", out_data, 128'hA);
        out_ready = 1'b1;
        step();
        check_val("bp_out_b", out_data, 128'hB);
        check_val("bp_out_b_ctrl", out_ctrl, 8'h02);
        check_val("bp_in_ready_back", in_ready, 1);
        step();
        check_val("bp_empty", out_valid, 0);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'hC;
        in_ctrl   = 8'h01;
        step();
        in_data = 128'hD;
        step();
        check_val("fl_skid_full", in_ready, 0);
        flush   = 1'b1;
        in_data = 128'hE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("fl_out_valid", out_valid, 0);
        check_val("fl_out_ctrl", out_ctrl, 0);
        check_val("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check_val("fl_no_ghost", out_valid, 0);
        end

        // ---------------- random traffic with scoreboard ----------------
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while ((sent < 1000 || rcvd < sent) && cyc < 20000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 99) < 70) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_ctrl  = 8'($urandom_range(1, 255));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (!out_valid)
                check_val("rnd_ctrl_zero", out_ctrl, 0);
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) begin
                    check_val("rnd_unexpected_beat", 1, 0);
                end else begin
                    check_val("rnd_data", out_data, q_data.pop_front());
                    check_val("rnd_ctrl", out_ctrl, q_ctrl.pop_front());
                end
                rcvd++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q_data.push_back(in_data);
                q_ctrl.push_back(in_ctrl);
                sent++;
            end
            step();
            if (acc)
                in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        check_val("rnd_rcvd_count", rcvd, 1000);
        check_val("rnd_sent_count", sent, 1000);

        // ---------------- reset mid-stall ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h11;
        in_ctrl   = 8'h05;
        step();
        in_data = 128'h22;
        step();
        in_valid = 1'b0;
        check_val("rs_stalled", in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rs_out_valid", out_valid, 0);
        check_val("rs_in_ready", in_ready, 1);
        check_val("rs_out_data", out_data, 0);

`ifdef PIPE_PERF_EN
        // ---------------- performance counters ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("pf_stall_rst", stall_cnt, 0);
        check_val("pf_bubble_rst", bubble_cnt, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h77;
        step();
        in_valid = 1'b0;
        check_val("pf_bubble_one", bubble_cnt, 1);
        repeat (20) step();
        check_val("pf_stall_sat", stall_cnt, 15);
        out_ready = 1'b1;
        step();
        check_val("pf_drained", out_valid, 0);
        repeat (3) step();
        check_val("pf_bubble_adv", bubble_cnt, 4);
        check_val("pf_stall_hold", stall_cnt, 15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
